// File: rtl/neg_edge_detector.sv
// Falling-edge detector: flags the cycle in which a synchronous input is low
// after having been sampled high on the previous clock edge.
module neg_edge_detector (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic din_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // History clears to 0 in reset, so releasing reset with din high never
  // produces a spurious falling edge, and reset kills a live pulse at once.
  assign dout = din_q & ~din;

endmodule

// File: tb/tb_neg_edge_detector.sv
// Scoreboard bench for neg_edge_detector: directed test-plan sequences plus
// randomized din/reset traffic against a "was high, is now low" model.
module tb_neg_edge_detector;

  logic clk;
  logic resetn;
  logic din;
  logic dout;

  int checks;
  int errors;
  bit exp_q[$];

  // Model state: last value of din captured by a clock edge while out of reset.
  bit prev_sampled;
  bit done;

  neg_edge_detector dut (
    .clk   (clk),
    .resetn(resetn),
    .din   (din),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input bit actual, input bit expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s @%0t: dout=%0b expected=%0b", name, $time, actual, expected);
    end
  endtask

  // One cycle of stimulus, applied at the falling clock edge. The expected
  // dout for the sampling point before the next rising edge is queued.
  task automatic step(input bit d, input bit rst_n_val);
    bit expected;
    @(negedge clk);
    resetn = rst_n_val;
    din    = d;
    expected = rst_n_val && prev_sampled && !d;
    exp_q.push_back(expected);
    prev_sampled = rst_n_val ? d : 1'b0;
  endtask

  // Monitor: dout is presented every cycle; sample just before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #6;
      if (exp_q.size() > 0) begin
        check("scoreboard", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    done = 1'b0;
    prev_sampled = 1'b0;
    resetn = 1'b0;
    din = 1'b0;

    // Reset held with din low, then released with din low: no pulse.
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    // Single falling edge.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // 1 high, 2 low, repeated twice.
    repeat (2) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
    end

    // Rising edge and steady high.
    step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Alternating every cycle.
    repeat (3) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end

    // Reset asserted asynchronously during a live pulse.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    #7;
    check("pulse_before_async_reset", dout, 1'b1);
    resetn = 1'b0;
    #1;
    check("async_reset_kills_pulse", dout, 1'b0);
    prev_sampled = 1'b0;

    // Release with din high: no false edge; then one genuine falling edge.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
    end
    step(1'b0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
